// File: rtl/mem_wb_if.sv
// MEM->WB boundary bundle: memory-stage inputs, write-back controls and the
// registered write-back results. master drives the memory side, slave is the
// MEM/WB register itself.
interface mem_wb_if;
    logic [31:0] Mem_Do;
    logic [31:0] Mem_ALUout;
    logic [4:0]  Mem_Rd;
    logic        Mem_RegWr;
    logic        Mem_MemtoReg;
    logic        Mem_Valid;
    logic [2:0]  Mem_LdType;
    logic        Wb_Stall;
    logic        Wb_Flush;

    logic [31:0] Wb_Data;
    logic [4:0]  Wb_Rd;
    logic        Wb_RegWr;
    logic        Wb_Valid;
    logic        Wb_AdEL;
    logic [31:0] Wb_BadAddr;
    logic [15:0] Wb_RetireCnt;

    modport master (
        output Mem_Do, Mem_ALUout, Mem_Rd, Mem_RegWr, Mem_MemtoReg, Mem_Valid,
               Mem_LdType, Wb_Stall, Wb_Flush,
        input  Wb_Data, Wb_Rd, Wb_RegWr, Wb_Valid, Wb_AdEL, Wb_BadAddr,
               Wb_RetireCnt
    );

    modport slave (
        input  Mem_Do, Mem_ALUout, Mem_Rd, Mem_RegWr, Mem_MemtoReg, Mem_Valid,
               Mem_LdType, Wb_Stall, Wb_Flush,
        output Wb_Data, Wb_Rd, Wb_RegWr, Wb_Valid, Wb_AdEL, Wb_BadAddr,
               Wb_RetireCnt
    );
endinterface

// File: rtl/mem_wb.sv
// MEM/WB pipeline register with load-lane extraction, sign/zero extension,
// optional misaligned-load (AdEL) detection and a retired-instruction counter.
// Optional feature: define MEM_WB_ADEL_EN to enable misalignment detection;
// without it Wb_AdEL/Wb_BadAddr are tied to 0 and no load is ever misaligned.
// Priority per edge: reset > flush > stall > capture.
module mem_wb #(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic     clk,
    input  logic     rst,
    mem_wb_if.slave  bus
);
    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LBU = 3'd2;
    localparam logic [2:0] LD_LH  = 3'd3;
    localparam logic [2:0] LD_LHU = 3'd4;

    logic [3:0][7:0]  lane_b;
    logic [1:0][15:0] lane_h;
    logic [1:0]       byte_sel;
    logic             half_sel;
    logic [7:0]       byte_val;
    logic [15:0]      half_val;
    logic [31:0]      load_val;
    logic             misaligned;

    logic [31:0] wb_data_q,    wb_data_d;
    logic [4:0]  wb_rd_q,      wb_rd_d;
    logic        wb_regwr_q,   wb_regwr_d;
    logic        wb_valid_q,   wb_valid_d;
    logic [15:0] retire_cnt_q, retire_cnt_d;
`ifdef MEM_WB_ADEL_EN
    logic        wb_adel_q,     wb_adel_d;
    logic [31:0] wb_bad_addr_q, wb_bad_addr_d;
`endif

    // Lane 0 is the least significant byte/halfword of the memory word.
    assign lane_b = bus.Mem_Do;
    assign lane_h = bus.Mem_Do;

    // Pick the addressed byte/halfword lane and extend it per load type.
    // Halfword lane uses only address bit 1, so bit 0 is ignored when the
    // alignment check is compiled out; lw never looks at the low address bits.
    always_comb begin
        byte_sel = BIG_ENDIAN ? (2'd3 - bus.Mem_ALUout[1:0]) : bus.Mem_ALUout[1:0];
        half_sel = BIG_ENDIAN ? ~bus.Mem_ALUout[1] : bus.Mem_ALUout[1];
        byte_val = lane_b[byte_sel];
        half_val = lane_h[half_sel];
        case (bus.Mem_LdType)
            LD_LB:   load_val = {{24{byte_val[7]}}, byte_val};
            LD_LBU:  load_val = {24'd0, byte_val};
            LD_LH:   load_val = {{16{half_val[15]}}, half_val};
            LD_LHU:  load_val = {16'd0, half_val};
            default: load_val = bus.Mem_Do;   // lw and reserved encodings
        endcase
    end

    // Misalignment only matters for a valid load; byte loads never fault.
    always_comb begin
        misaligned = 1'b0;
`ifdef MEM_WB_ADEL_EN
        if (bus.Mem_Valid && bus.Mem_MemtoReg) begin
            case (bus.Mem_LdType)
                LD_LB, LD_LBU: misaligned = 1'b0;
                LD_LH, LD_LHU: misaligned = bus.Mem_ALUout[0];
                default:       misaligned = |bus.Mem_ALUout[1:0];
            endcase
        end
`endif
    end

    // Next-state: flush clears everything but the counter, stall holds all,
    // otherwise capture the memory-stage instruction.
    always_comb begin
        wb_data_d    = wb_data_q;
        wb_rd_d      = wb_rd_q;
        wb_regwr_d   = wb_regwr_q;
        wb_valid_d   = wb_valid_q;
        retire_cnt_d = retire_cnt_q;
`ifdef MEM_WB_ADEL_EN
        wb_adel_d     = wb_adel_q;
        wb_bad_addr_d = wb_bad_addr_q;
`endif
        if (bus.Wb_Flush) begin
            wb_data_d  = 32'd0;
            wb_rd_d    = 5'd0;
            wb_regwr_d = 1'b0;
            wb_valid_d = 1'b0;
`ifdef MEM_WB_ADEL_EN
            wb_adel_d     = 1'b0;
            wb_bad_addr_d = 32'd0;
`endif
        end else if (!bus.Wb_Stall) begin
            wb_data_d    = bus.Mem_MemtoReg ? load_val : bus.Mem_ALUout;
            wb_rd_d      = bus.Mem_Rd;
            wb_valid_d   = bus.Mem_Valid;
            wb_regwr_d   = bus.Mem_RegWr && bus.Mem_Valid && (bus.Mem_Rd != 5'd0) && !misaligned;
            // Misaligned loads still retire (they raise the exception).
            retire_cnt_d = retire_cnt_q + {15'd0, bus.Mem_Valid};
`ifdef MEM_WB_ADEL_EN
            wb_adel_d     = misaligned;
            wb_bad_addr_d = misaligned ? bus.Mem_ALUout : 32'd0;
`endif
        end
    end

    // State registers, cleared asynchronously while rst is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_data_q    <= 32'd0;
            wb_rd_q      <= 5'd0;
            wb_regwr_q   <= 1'b0;
            wb_valid_q   <= 1'b0;
            retire_cnt_q <= 16'd0;
`ifdef MEM_WB_ADEL_EN
            wb_adel_q     <= 1'b0;
            wb_bad_addr_q <= 32'd0;
`endif
        end else begin
            wb_data_q    <= wb_data_d;
            wb_rd_q      <= wb_rd_d;
            wb_regwr_q   <= wb_regwr_d;
            wb_valid_q   <= wb_valid_d;
            retire_cnt_q <= retire_cnt_d;
`ifdef MEM_WB_ADEL_EN
            wb_adel_q     <= wb_adel_d;
            wb_bad_addr_q <= wb_bad_addr_d;
`endif
        end
    end

    assign bus.Wb_Data      = wb_data_q;
    assign bus.Wb_Rd        = wb_rd_q;
    assign bus.Wb_RegWr     = wb_regwr_q;
    assign bus.Wb_Valid     = wb_valid_q;
    assign bus.Wb_RetireCnt = retire_cnt_q;
`ifdef MEM_WB_ADEL_EN
    assign bus.Wb_AdEL      = wb_adel_q;
    assign bus.Wb_BadAddr   = wb_bad_addr_q;
`else
    assign bus.Wb_AdEL      = 1'b0;
    assign bus.Wb_BadAddr   = 32'd0;
`endif
endmodule

// File: tb/tb_mem_wb.sv
// Bench for mem_wb: little- and big-endian instances driven in lockstep and
// checked against a behavioural model built from the load/lane rules.
module tb_mem_wb;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_wb_if if_le();
    mem_wb_if if_be();

    mem_wb #(.BIG_ENDIAN(1'b0)) dut_le (.clk(clk), .rst(rst), .bus(if_le.slave));
    mem_wb #(.BIG_ENDIAN(1'b1)) dut_be (.clk(clk), .rst(rst), .bus(if_be.slave));

`ifdef MEM_WB_ADEL_EN
    localparam bit ADEL = 1'b1;
`else
    localparam bit ADEL = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] mdo;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        regwr;
        logic        m2r;
        logic        valid;
        logic [2:0]  ld;
        logic        stall;
        logic        flush;
    } in_t;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        regwr;
        logic        valid;
        logic        adel;
        logic [31:0] bad;
        logic [15:0] cnt;
    } out_t;

    in_t  cur;
    out_t exp_le, exp_be;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference: what the write-back register should hold after one edge.
    function automatic out_t model_step(input out_t prev, input in_t s, input bit be);
        out_t n;
        logic [7:0] b [4];
        int a, bi, hi;
        logic [7:0]  bv;
        logic [15:0] hv;
        logic [31:0] lv;
        bit mis;
        n = prev;
        if (s.flush) begin
            n = '0;
            n.cnt = prev.cnt;
        end else if (!s.stall) begin
            for (int i = 0; i < 4; i++) b[i] = s.mdo[8*i +: 8];
            a  = int'(s.alu[1:0]);
            bi = be ? 3 - a : a;
            hi = be ? 1 - a / 2 : a / 2;
            bv = b[bi];
            hv = {b[2*hi+1], b[2*hi]};
            case (s.ld)
                3'd1:    lv = {{24{bv[7]}}, bv};
                3'd2:    lv = {24'd0, bv};
                3'd3:    lv = {{16{hv[15]}}, hv};
                3'd4:    lv = {16'd0, hv};
                default: lv = s.mdo;
            endcase
            mis = 1'b0;
            if (ADEL && s.valid && s.m2r) begin
                if (s.ld == 3'd3 || s.ld == 3'd4) mis = (a % 2) != 0;
                else if (s.ld != 3'd1 && s.ld != 3'd2) mis = (a != 0);
            end
            n.data  = s.m2r ? lv : s.alu;
            n.rd    = s.rd;
            n.valid = s.valid;
            n.regwr = s.regwr && s.valid && (s.rd != 0) && !mis;
            n.adel  = mis;
            n.bad   = mis ? s.alu : 32'd0;
            n.cnt   = prev.cnt + (s.valid ? 16'd1 : 16'd0);
        end
        return n;
    endfunction

    function automatic out_t obs(input bit be);
        if (be)
            return out_t'({if_be.Wb_Data, if_be.Wb_Rd, if_be.Wb_RegWr, if_be.Wb_Valid,
                           if_be.Wb_AdEL, if_be.Wb_BadAddr, if_be.Wb_RetireCnt});
        return out_t'({if_le.Wb_Data, if_le.Wb_Rd, if_le.Wb_RegWr, if_le.Wb_Valid,
                       if_le.Wb_AdEL, if_le.Wb_BadAddr, if_le.Wb_RetireCnt});
    endfunction

    function automatic in_t rand_in();
        in_t s;
        s.mdo   = $urandom;
        s.alu   = $urandom;
        s.rd    = 5'($urandom_range(0, 31));
        s.regwr = 1'($urandom_range(0, 1));
        s.m2r   = 1'($urandom_range(0, 1));
        s.valid = ($urandom_range(0, 3) != 0);
        s.ld    = 3'($urandom_range(0, 7));
        s.stall = ($urandom_range(0, 7) == 0);
        s.flush = ($urandom_range(0, 15) == 0);
        return s;
    endfunction

    function automatic in_t mk_load(input logic [31:0] mdo, input logic [31:0] alu,
                                    input logic [2:0] ld, input logic [4:0] rd);
        in_t s;
        s = '0;
        s.mdo = mdo; s.alu = alu; s.ld = ld; s.rd = rd;
        s.regwr = 1'b1; s.m2r = 1'b1; s.valid = 1'b1;
        return s;
    endfunction

    task automatic drive(input in_t s);
        cur = s;
        if_le.Mem_Do = s.mdo;   if_be.Mem_Do = s.mdo;
        if_le.Mem_ALUout = s.alu; if_be.Mem_ALUout = s.alu;
        if_le.Mem_Rd = s.rd;    if_be.Mem_Rd = s.rd;
        if_le.Mem_RegWr = s.regwr; if_be.Mem_RegWr = s.regwr;
        if_le.Mem_MemtoReg = s.m2r; if_be.Mem_MemtoReg = s.m2r;
        if_le.Mem_Valid = s.valid; if_be.Mem_Valid = s.valid;
        if_le.Mem_LdType = s.ld; if_be.Mem_LdType = s.ld;
        if_le.Wb_Stall = s.stall; if_be.Wb_Stall = s.stall;
        if_le.Wb_Flush = s.flush; if_be.Wb_Flush = s.flush;
    endtask

    // One rising edge: advance the model, then settle 1ns past the edge.
    task automatic step();
        @(posedge clk);
        exp_le = model_step(exp_le, cur, 1'b0);
        exp_be = model_step(exp_be, cur, 1'b1);
        #1;
    endtask

    task automatic test_reset();
        drive('0);
        exp_le = '0; exp_be = '0;
        #2;
        n_cmp++;
        if (obs(0) !== '0 || obs(1) !== '0) begin
            n_bad++; $display("FAIL reset_state le=%h be=%h exp=0", obs(0), obs(1));
        end
        #6 rst = 1'b1;   // released between edges
    endtask

    task automatic test_lanes();
        in_t s;
        // lb addr 3 (LE) -> FFFFFF80
        drive(mk_load(32'h80FF7F01, 32'd3, 3'd1, 5'd4)); step();
        n_cmp++;
        if (if_le.Wb_Data !== 32'hFFFFFF80) begin
            n_bad++; $display("FAIL lb_a3 got=%h exp=FFFFFF80", if_le.Wb_Data);
        end
        // lbu addr 2 (LE) picks the FF byte
        drive(mk_load(32'h80FF7F01, 32'd2, 3'd2, 5'd4)); step();
        n_cmp++;
        if (if_le.Wb_Data !== 32'h000000FF) begin
            n_bad++; $display("FAIL lbu_a2 got=%h exp=000000FF", if_le.Wb_Data);
        end
        // lbu addr 1: byte 1 of this word is 7F
        drive(mk_load(32'h80FF7F01, 32'd1, 3'd2, 5'd4)); step();
        n_cmp++;
        if (obs(0) !== exp_le || obs(1) !== exp_be) begin
            n_bad++; $display("FAIL lbu_a1 le=%h be=%h exp_le=%h exp_be=%h", obs(0), obs(1), exp_le, exp_be);
        end
        // lh addr 2: LE FFFF80FF, BE 00007F01
        drive(mk_load(32'h80FF7F01, 32'd2, 3'd3, 5'd4)); step();
        n_cmp++;
        if (if_le.Wb_Data !== 32'hFFFF80FF || if_be.Wb_Data !== 32'h00007F01) begin
            n_bad++; $display("FAIL lh_a2 le=%h be=%h exp=FFFF80FF/00007F01", if_le.Wb_Data, if_be.Wb_Data);
        end
        drive(mk_load(32'h80FF7F01, 32'd2, 3'd4, 5'd4)); step();
        n_cmp++;
        if (if_le.Wb_Data !== 32'h000080FF) begin
            n_bad++; $display("FAIL lhu_a2 got=%h exp=000080FF", if_le.Wb_Data);
        end
        // non-load passes ALU result
        s = mk_load(32'h12345678, 32'hCAFEF00D, 3'd1, 5'd9); s.m2r = 1'b0;
        drive(s); step();
        n_cmp++;
        if (if_be.Wb_Data !== 32'hCAFEF00D || obs(0) !== exp_le) begin
            n_bad++; $display("FAIL alu_pass got=%h exp=CAFEF00D", if_be.Wb_Data);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(rand_in()); step();
            n_cmp++;
            if (obs(0) !== exp_le || obs(1) !== exp_be) begin
                n_bad++; $display("FAIL random[%0d] le=%h be=%h exp_le=%h exp_be=%h", i, obs(0), obs(1), exp_le, exp_be);
            end
        end
    endtask

    task automatic test_stall_flush();
        out_t hold_le, hold_be;
        in_t s;
        drive(mk_load(32'hA5A5_1234, 32'd0, 3'd0, 5'd7)); step();
        hold_le = obs(0); hold_be = obs(1);
        for (int i = 0; i < 3; i++) begin
            s = rand_in(); s.stall = 1'b1; s.flush = 1'b0; s.valid = 1'b1;
            drive(s); step();
            n_cmp++;
            if (obs(0) !== hold_le || obs(1) !== hold_be || obs(0) !== exp_le) begin
                n_bad++; $display("FAIL stall[%0d] le=%h exp=%h", i, obs(0), hold_le);
            end
        end
        s = rand_in(); s.stall = 1'b1; s.flush = 1'b1; s.valid = 1'b1;
        drive(s); step();
        n_cmp++;
        if (if_le.Wb_Valid !== 1'b0 || if_le.Wb_RegWr !== 1'b0 || if_le.Wb_Data !== 32'd0 ||
            if_le.Wb_RetireCnt !== hold_le.cnt || if_be.Wb_RetireCnt !== hold_be.cnt) begin
            n_bad++; $display("FAIL stall_flush v=%b w=%b cnt=%h exp_cnt=%h", if_le.Wb_Valid,
                              if_le.Wb_RegWr, if_le.Wb_RetireCnt, hold_le.cnt);
        end
    endtask

    task automatic test_adel();
        drive(mk_load(32'h11223344, 32'h00001002, 3'd0, 5'd3)); step();
`ifdef MEM_WB_ADEL_EN
        n_cmp++;
        if (if_le.Wb_AdEL !== 1'b1 || if_le.Wb_BadAddr !== 32'h00001002 || if_le.Wb_RegWr !== 1'b0) begin
            n_bad++; $display("FAIL adel_set adel=%b bad=%h w=%b exp=1/00001002/0",
                              if_le.Wb_AdEL, if_le.Wb_BadAddr, if_le.Wb_RegWr);
        end
`else
        n_cmp++;
        if (if_le.Wb_AdEL !== 1'b0 || if_le.Wb_BadAddr !== 32'd0 || if_le.Wb_RegWr !== 1'b1 ||
            if_le.Wb_Data !== 32'h11223344) begin
            n_bad++; $display("FAIL adel_off adel=%b bad=%h w=%b d=%h exp=0/0/1/11223344",
                              if_le.Wb_AdEL, if_le.Wb_BadAddr, if_le.Wb_RegWr, if_le.Wb_Data);
        end
`endif
        n_cmp++;
        if (obs(0) !== exp_le || obs(1) !== exp_be) begin
            n_bad++; $display("FAIL adel_model le=%h exp=%h", obs(0), exp_le);
        end
        drive(mk_load(32'h11223344, 32'h00001004, 3'd0, 5'd3)); step();
        n_cmp++;
        if (if_le.Wb_AdEL !== 1'b0 || if_le.Wb_RegWr !== 1'b1 || obs(1) !== exp_be) begin
            n_bad++; $display("FAIL adel_clear adel=%b w=%b exp=0/1", if_le.Wb_AdEL, if_le.Wb_RegWr);
        end
        // misaligned halfword, same expectations through the model
        drive(mk_load(32'h11223344, 32'h00002001, 3'd3, 5'd6)); step();
        n_cmp++;
        if (obs(0) !== exp_le || obs(1) !== exp_be) begin
            n_bad++; $display("FAIL adel_lh le=%h exp=%h", obs(0), exp_le);
        end
    endtask

    task automatic test_rd_zero();
        in_t s;
        s = mk_load(32'h0, 32'h55, 3'd0, 5'd0); s.m2r = 1'b0;
        drive(s); step();
        n_cmp++;
        if (if_le.Wb_RegWr !== 1'b0 || if_le.Wb_Valid !== 1'b1) begin
            n_bad++; $display("FAIL rd_zero w=%b v=%b exp=0/1", if_le.Wb_RegWr, if_le.Wb_Valid);
        end
    endtask

    task automatic test_async_reset();
        drive(mk_load(32'hDEADBEEF, 32'd0, 3'd0, 5'd12)); step();
        #2 rst = 1'b0;
        #1;
        exp_le = '0; exp_be = '0;
        n_cmp++;
        if (obs(0) !== '0 || obs(1) !== '0) begin
            n_bad++; $display("FAIL async_reset le=%h be=%h exp=0", obs(0), obs(1));
        end
        #2 rst = 1'b1;
        drive(mk_load(32'hDEADBEEF, 32'd0, 3'd0, 5'd12)); step();
        n_cmp++;
        if (if_le.Wb_Data !== 32'hDEADBEEF || if_le.Wb_RetireCnt !== 16'd1 || obs(1) !== exp_be) begin
            n_bad++; $display("FAIL post_reset d=%h cnt=%h exp=DEADBEEF/1", if_le.Wb_Data, if_le.Wb_RetireCnt);
        end
    endtask

    task automatic test_wrap();
        in_t s;
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        exp_le = '0; exp_be = '0;
        for (int i = 0; i < 65536; i++) begin
            s = rand_in(); s.valid = 1'b1; s.stall = 1'b0; s.flush = 1'b0;
            drive(s); step();
            if (i == 65534) begin
                n_cmp++;
                if (if_le.Wb_RetireCnt !== 16'hFFFF) begin
                    n_bad++; $display("FAIL cnt_ffff got=%h exp=FFFF", if_le.Wb_RetireCnt);
                end
            end
        end
        n_cmp++;
        if (if_le.Wb_RetireCnt !== 16'd0 || if_be.Wb_RetireCnt !== 16'd0 || obs(0) !== exp_le) begin
            n_bad++; $display("FAIL cnt_wrap le=%h be=%h exp=0", if_le.Wb_RetireCnt, if_be.Wb_RetireCnt);
        end
    endtask

    initial begin
        test_reset();
        test_lanes();
        test_rd_zero();
        test_stall_flush();
        test_adel();
        test_random();
        test_async_reset();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
